lp_circ_queue: RTL and testbench



---
 rtl/lp_circ_queue.sv | 176 +++++++++++++++++
 tb/tb_lp_circ_queue.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/lp_circ_queue.sv
// lp_circ_queue
// Stereo circular sample queue feeding the low-pass FIR stage. Samples are
// written into a per-channel circular buffer. Once TAPS samples have been
// collected, each new sample starts a read-out burst of the TAPS-sample
// window, oldest first, one sample per clock.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   wrt_smpl   single-cycle strobe, lft_smpl/rght_smpl valid this cycle
//   lft_smpl   signed 16-bit left sample in
//   rght_smpl  signed 16-bit right sample in
//   lft_out    left sample being sequenced (registered, holds when idle)
//   rght_out   right sample being sequenced (registered, holds when idle)
//   sequencing high exactly while lft_out/rght_out carry burst data
//   ovr        sticky overrun flag, cleared only by reset
module lp_circ_queue #(
    parameter int DEPTH = 1024,
    parameter int TAPS  = 1021
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt_smpl,
    input  logic [15:0] lft_smpl,
    input  logic [15:0] rght_smpl,
    output logic [15:0] lft_out,
    output logic [15:0] rght_out,
    output logic        sequencing,
    output logic        ovr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TAPS + 1);
    localparam int RW = $clog2(TAPS);

    localparam logic [CW-1:0] CNT_LAST = CW'(TAPS - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(TAPS);
    localparam logic [RW-1:0] RD_LAST  = RW'(TAPS - 1);

    typedef enum logic [1:0] {FILL, READY, BURST, GAP} state_t;

    state_t        state_reg,   state_next;
    logic [CW-1:0] cnt_reg,     cnt_next;
    logic [AW-1:0] new_ptr_reg, new_ptr_next;
    logic [AW-1:0] old_ptr_reg, old_ptr_next;
    logic [AW-1:0] rd_ptr_reg,  rd_ptr_next;
    logic [RW-1:0] rd_cnt_reg,  rd_cnt_next;
    logic          pending_reg, pending_next;
    logic          ovr_reg,     ovr_next;
    logic          seq_reg;
    logic          rd_en;

    logic [1:0][15:0] smpl_in;
    assign smpl_in = {rght_smpl, lft_smpl};

    // Next-state logic. Writes are accepted in every state.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        new_ptr_next = new_ptr_reg;
        old_ptr_next = old_ptr_reg;
        rd_ptr_next  = rd_ptr_reg;
        rd_cnt_next  = rd_cnt_reg;
        pending_next = pending_reg;
        ovr_next     = ovr_reg;
        rd_en        = 1'b0;

        if (wrt_smpl) begin
            new_ptr_next = new_ptr_reg + AW'(1);
            if (cnt_reg != CNT_FULL) begin
                cnt_next = cnt_reg + CW'(1);
            end
        end

        case (state_reg)
            FILL: begin
                if (wrt_smpl && cnt_reg == CNT_LAST) begin
                    state_next  = BURST;
                    rd_ptr_next = old_ptr_reg;
                    rd_cnt_next = '0;
                end
            end
            READY: begin
                if (wrt_smpl) begin
                    state_next  = BURST;
                    rd_ptr_next = old_ptr_reg;
                    rd_cnt_next = '0;
                end
            end
            BURST: begin
                rd_en       = 1'b1;
                rd_ptr_next = rd_ptr_reg + AW'(1);
                rd_cnt_next = rd_cnt_reg + RW'(1);
                // Only one burst can be queued; a second write flags overrun.
                if (wrt_smpl) begin
                    if (pending_reg) begin
                        ovr_next = 1'b1;
                    end else begin
                        pending_next = 1'b1;
                    end
                end
                if (rd_cnt_reg == RD_LAST) begin
                    // Slide the window by one sample for the next burst.
                    old_ptr_next = old_ptr_reg + AW'(1);
                    // A write on the last read cycle also counts as pending.
                    state_next   = (pending_reg || wrt_smpl) ? GAP : READY;
                end
            end
            GAP: begin
                // Pending is always set here, so any write is an overrun.
                if (wrt_smpl) begin
                    ovr_next = 1'b1;
                end
                state_next   = BURST;
                pending_next = 1'b0;
                rd_ptr_next  = old_ptr_reg;
                rd_cnt_next  = '0;
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= FILL;
            cnt_reg     <= '0;
            new_ptr_reg <= '0;
            old_ptr_reg <= '0;
            rd_ptr_reg  <= '0;
            rd_cnt_reg  <= '0;
            pending_reg <= 1'b0;
            ovr_reg     <= 1'b0;
            seq_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            new_ptr_reg <= new_ptr_next;
            old_ptr_reg <= old_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            rd_cnt_reg  <= rd_cnt_next;
            pending_reg <= pending_next;
            ovr_reg     <= ovr_next;
            seq_reg     <= rd_en;
        end
    end

    // Per-channel storage: index 0 is left, index 1 is right. The read
    // register only loads on a read, so the output holds between bursts.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [15:0] mem [DEPTH];
            logic [15:0] dout_reg;

            always_ff @(posedge clk) begin
                if (wrt_smpl) begin
                    mem[new_ptr_reg] <= smpl_in[gi];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_reg <= '0;
                end else if (rd_en) begin
                    dout_reg <= mem[rd_ptr_reg];
                end
            end
        end
    endgenerate

    assign lft_out    = g_chan[0].dout_reg;
    assign rght_out   = g_chan[1].dout_reg;
    assign sequencing = seq_reg;
    assign ovr        = ovr_reg;

endmodule

// File: tb/tb_lp_circ_queue.sv
// Directed testbench for lp_circ_queue using a small configuration
// (DEPTH 16, TAPS 13) so that the window slides across the pointer wrap
// many times. Sample n is written as left = n, right = -n, so the burst
// that starts at window base b must output b+k / -(b+k) for k = 0..TAPS-1.
module tb_lp_circ_queue;

    localparam int DEPTH = 16;
    localparam int TAPS  = 13;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wrt_smpl = 1'b0;
    logic [15:0] lft_smpl = '0;
    logic [15:0] rght_smpl = '0;
    logic [15:0] lft_out;
    logic [15:0] rght_out;
    logic        sequencing;
    logic        ovr;

    int checks = 0;
    int errors = 0;
    int next_n = 0;
    int bidx   = 0;

    lp_circ_queue #(.DEPTH(DEPTH), .TAPS(TAPS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wrt_smpl   (wrt_smpl),
        .lft_smpl   (lft_smpl),
        .rght_smpl  (rght_smpl),
        .lft_out    (lft_out),
        .rght_out   (rght_out),
        .sequencing (sequencing),
        .ovr        (ovr)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of input (optionally a write of sample next_n), then
    // advance to 1 time unit past the next rising edge.
    task automatic tick(input logic w);
        wrt_smpl  = w;
        lft_smpl  = 16'(next_n);
        rght_smpl = 16'(-next_n);
        @(posedge clk);
        #1;
        if (w) next_n++;
        wrt_smpl = 1'b0;
    endtask

    // Check TAPS cycles of burst data starting at window base, optionally
    // writing extra samples during burst cycles wa and wb, then check the
    // low cycle that follows.
    task automatic burst_body(input int base, input int wa, input int wb);
        for (int k = 0; k < TAPS; k++) begin
            tick(k == wa || k == wb);
            check("seq_burst", {15'b0, sequencing}, 16'd1);
            check("lft_data", lft_out, 16'(base + k));
            check("rght_data", rght_out, 16'(-(base + k)));
        end
        tick(1'b0);
        check("seq_after", {15'b0, sequencing}, 16'd0);
        $display("burst base=%0d done, ovr=%0b", base, ovr);
    endtask

    task automatic trigger_burst(input int base, input int wa, input int wb);
        tick(1'b1);
        check("seq_t1", {15'b0, sequencing}, 16'd0);
        burst_body(base, wa, wb);
    endtask

    initial begin
        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_lft", lft_out, 16'd0);
        check("rst_rght", rght_out, 16'd0);
        check("rst_seq", {15'b0, sequencing}, 16'd0);
        check("rst_ovr", {15'b0, ovr}, 16'd0);
        rst_n = 1'b1;

        // TAPS-1 writes: still filling, no burst.
        for (int i = 0; i < TAPS - 1; i++) begin
            tick(1'b1);
            check("fill_seq", {15'b0, sequencing}, 16'd0);
        end

        // First burst, then sliding window across several pointer wraps.
        trigger_burst(0, -1, -1);
        bidx = 1;
        for (int i = 0; i < 30; i++) begin
            trigger_burst(bidx, -1, -1);
            bidx++;
        end
        check("slide_ovr", {15'b0, ovr}, 16'd0);

        // Single pending write mid-burst: one low cycle, then advanced window.
        trigger_burst(bidx, 5, -1);
        burst_body(bidx + 1, -1, -1);
        bidx += 2;
        check("pend_ovr", {15'b0, ovr}, 16'd0);

        // Write on the same cycle as the last read address also queues a burst.
        trigger_burst(bidx, TAPS - 1, -1);
        burst_body(bidx + 1, -1, -1);
        bidx += 2;
        check("pend_last_ovr", {15'b0, ovr}, 16'd0);
        repeat (3) begin
            tick(1'b0);
            check("ready_idle", {15'b0, sequencing}, 16'd0);
        end

        // Overrun: two writes during one burst, only one extra burst runs.
        trigger_burst(bidx, 3, 7);
        check("ovr_set", {15'b0, ovr}, 16'd1);
        burst_body(bidx + 1, -1, -1);
        bidx += 2;
        repeat (4) begin
            tick(1'b0);
            check("ovr_single_extra", {15'b0, sequencing}, 16'd0);
        end
        check("ovr_sticky", {15'b0, ovr}, 16'd1);

        // Both overrun samples stay stored and show up in later windows.
        for (int i = 0; i < 3; i++) begin
            trigger_burst(bidx, -1, -1);
            bidx++;
        end
        check("ovr_still", {15'b0, ovr}, 16'd1);

        // Reset in the middle of a burst clears outputs immediately.
        tick(1'b1);
        repeat (6) tick(1'b0);
        check("pre_rst_seq", {15'b0, sequencing}, 16'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_seq", {15'b0, sequencing}, 16'd0);
        check("mid_rst_lft", lft_out, 16'd0);
        check("mid_rst_rght", rght_out, 16'd0);
        check("mid_rst_ovr", {15'b0, ovr}, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Refill from scratch: TAPS-1 writes give no burst, the next does.
        bidx = next_n;
        for (int i = 0; i < TAPS - 1; i++) begin
            tick(1'b1);
            check("refill_seq", {15'b0, sequencing}, 16'd0);
        end
        trigger_burst(bidx, -1, -1);
        check("final_ovr", {15'b0, ovr}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
